// File: rtl/uart_status_pkg.sv
// uart_status_pkg: shared formatter states, ASCII constants and hex helper.
package uart_status_pkg;

    typedef enum logic [2:0] {
        S_HOLDOFF,
        S_IDLE,
        S_SNAP,
        S_HDR,
        S_PREFIX,
        S_DIGITS,
        S_EOL
    } fmt_state_e;

    localparam logic [7:0] ESC    = 8'd27;
    localparam logic [7:0] LBRACK = 8'd91;
    localparam logic [7:0] CHAR_H = 8'd72;
    localparam logic [7:0] CR     = 8'd13;
    localparam logic [7:0] LF     = 8'd10;
    localparam logic [7:0] COLON  = 8'd58;
    localparam logic [7:0] SPACE  = 8'd32;
    localparam logic [7:0] CHAR_C = 8'd67;

    function automatic logic [7:0] hex_to_ascii(input logic [3:0] d);
        return (d < 4'd10) ? 8'h30 + {4'h0, d} : 8'h37 + {4'h0, d};
    endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: 8N1 transmitter fed from a first-word-fall-through FIFO.
module uart_tx_serializer #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       empty_i,
    input  logic [7:0] data_i,
    output logic       pop_o,
    output logic       tx_o,
    output logic       active_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    logic          active_q, active_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_q, bit_d;
    logic [8:0]    sh_q, sh_d;
    logic          tx_q, tx_d;
    logic          bit_end, last;

    assign bit_end  = cnt_q == CW'(CLKS_PER_BIT - 1);
    assign last     = active_q && bit_end && bit_q == 4'd9;
    // Reloading on the final stop-bit cycle keeps consecutive bytes gap-free.
    assign pop_o    = !empty_i && (!active_q || last);
    assign tx_o     = tx_q;
    assign active_o = active_q;

    always_comb begin
        active_d = active_q;
        cnt_d    = bit_end ? '0 : cnt_q + 1'b1;
        bit_d    = bit_q;
        sh_d     = sh_q;
        tx_d     = tx_q;
        if (pop_o) begin
            active_d = 1'b1;
            cnt_d    = '0;
            bit_d    = '0;
            sh_d     = {1'b1, data_i};
            tx_d     = 1'b0;
        end else if (!active_q) begin
            cnt_d = '0;
        end else if (last) begin
            active_d = 1'b0;
            tx_d     = 1'b1;
        end else if (bit_end) begin
            bit_d = bit_q + 1'b1;
            tx_d  = sh_q[0];
            sh_d  = {1'b0, sh_q[8:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            bit_q    <= '0;
            sh_q     <= '0;
            tx_q     <= 1'b1;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            sh_q     <= sh_d;
            tx_q     <= tx_d;
        end
    end

endmodule

// File: rtl/uart_status_reporter.sv
// uart_status_reporter: snapshots channel values, formats them as hex text
// lines behind a home-cursor escape, and streams them out over an 8N1 UART.
module uart_status_reporter
    import uart_status_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int VAL_W        = 8,
    parameter int CLKS_PER_BIT = 5208,
    parameter int HOLDOFF      = 110,
    parameter int FIFO_DEPTH   = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [NUM_CH*VAL_W-1:0]       ch_values,
    output logic                          tx,
    output logic                          busy,
    output logic                          frame_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int NDIG = (VAL_W + 3) / 4;
    localparam int XW   = 4 * NDIG;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CHW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int HW   = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(FIFO_DEPTH);

    fmt_state_e               state_q, state_d;
    logic [HW-1:0]            hcnt_q, hcnt_d;
    logic [2:0]               idx_q, idx_d;
    logic [CHW-1:0]           ch_q, ch_d;
    logic [NUM_CH*VAL_W-1:0]  snap_q, snap_d;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q, cnt_d;

    logic             fifo_full, fifo_empty, push, pop, emit, at_end, last_ch, ser_active;
    logic [7:0]       byte_w, head;
    logic [VAL_W-1:0] cur;
    logic [3:0]       digit;

    assign fifo_full  = cnt_q == FULL_LVL;
    assign fifo_empty = cnt_q == '0;
    assign head       = mem_q[rd_q];
    assign fifo_level = cnt_q;
    assign cnt_d      = (push && !pop) ? cnt_q + 1'b1 : (pop && !push) ? cnt_q - 1'b1 : cnt_q;

    assign cur     = snap_q[ch_q*VAL_W +: VAL_W];
    assign digit   = 4'(XW'(cur) >> (4 * (NDIG - 1 - int'(idx_q))));
    assign emit    = state_q inside {S_HDR, S_PREFIX, S_DIGITS, S_EOL};
    // A full FIFO simply withholds the push, freezing the index until space frees up.
    assign push    = emit && !fifo_full;
    assign last_ch = ch_q == CHW'(NUM_CH - 1);

    assign frame_done = push && state_q == S_EOL && at_end && last_ch;
    assign busy       = (state_q != S_IDLE && state_q != S_HOLDOFF) || !fifo_empty || ser_active;

    always_comb begin
        byte_w = 8'h00;
        at_end = 1'b0;
        case (state_q)
            S_HDR: begin
                byte_w = (idx_q == 3'd0) ? ESC : (idx_q == 3'd1) ? LBRACK : CHAR_H;
                at_end = idx_q == 3'd2;
            end
            S_PREFIX: begin
                byte_w = (idx_q == 3'd0) ? CHAR_C :
                         (idx_q == 3'd1) ? hex_to_ascii(4'(ch_q)) :
                         (idx_q == 3'd2) ? COLON : SPACE;
                at_end = idx_q == 3'd3;
            end
            S_DIGITS: begin
                byte_w = hex_to_ascii(digit);
                at_end = idx_q == 3'(NDIG - 1);
            end
            S_EOL: begin
                byte_w = (idx_q == 3'd0) ? CR : LF;
                at_end = idx_q == 3'd1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        idx_d   = idx_q;
        ch_d    = ch_q;
        snap_d  = snap_q;
        case (state_q)
            S_HOLDOFF: begin
                hcnt_d = hcnt_q + 1'b1;
                if (hcnt_q == HW'(HOLDOFF - 1)) state_d = S_IDLE;
            end
            S_IDLE: if (enable && fifo_empty) state_d = S_SNAP;
            S_SNAP: begin
                snap_d  = ch_values;
                idx_d   = '0;
                ch_d    = '0;
                state_d = S_HDR;
            end
            default: if (push) begin
                idx_d = at_end ? '0 : idx_q + 1'b1;
                if (at_end) begin
                    state_d = (state_q == S_HDR)    ? S_PREFIX :
                              (state_q == S_PREFIX) ? S_DIGITS :
                              (state_q == S_DIGITS) ? S_EOL    :
                              last_ch               ? S_IDLE   : S_PREFIX;
                    if (state_q == S_EOL && !last_ch) ch_d = ch_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_HOLDOFF;
            hcnt_q  <= '0;
            idx_q   <= '0;
            ch_q    <= '0;
            snap_q  <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            idx_q   <= idx_d;
            ch_q    <= ch_d;
            snap_q  <= snap_d;
            wr_q    <= push ? wr_q + 1'b1 : wr_q;
            rd_q    <= pop ? rd_q + 1'b1 : rd_q;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= byte_w;
    end

    uart_tx_serializer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_ser (
        .clk      (clk),
        .rst      (rst),
        .empty_i  (fifo_empty),
        .data_i   (head),
        .pop_o    (pop),
        .tx_o     (tx),
        .active_o (ser_active)
    );

endmodule

// File: tb/tb_uart_status_reporter.sv
// tb_uart_status_reporter: scoreboard bench decoding the UART line against expected frames.
module tb_uart_status_reporter;

    logic        clk = 1'b0;
    logic        rst, enable;
    logic [15:0] ch_values;
    logic        tx, busy, frame_done;
    logic [4:0]  fifo_level;

    int n_cmp = 0, n_err = 0, cyc = 0, fd_cnt = 0, rx_cnt = 0;
    logic [7:0] exp_q [$];
    int         start_q [$];

    uart_status_reporter #(
        .NUM_CH(2), .VAL_W(8), .CLKS_PER_BIT(4), .HOLDOFF(8), .FIFO_DEPTH(16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .ch_values  (ch_values),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (frame_done === 1'b1) fd_cnt <= fd_cnt + 1;

    // UART receiver: samples every negedge over one 40-cycle character.
    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && tx === 1'b0) begin
                logic s [0:37];
                logic [7:0] b, e;
                bit ok, fmt;
                int t0;
                t0 = cyc; s[0] = tx; ok = 1;
                for (int k = 1; k < 38; k++) begin
                    @(negedge clk);
                    if (rst !== 1'b0) begin ok = 0; break; end
                    s[k] = tx;
                end
                if (ok) begin
                    fmt = 1;
                    for (int i = 0; i < 4; i++) if (s[i] !== 1'b0) fmt = 0;
                    for (int i = 0; i < 8; i++) begin
                        b[i] = s[4*i+4];
                        for (int j = 1; j < 4; j++) if (s[4*i+4+j] !== s[4*i+4]) fmt = 0;
                    end
                    if (s[36] !== 1'b1 || s[37] !== 1'b1) fmt = 0;
                    n_cmp++;
                    if (!fmt) begin
                        n_err++;
                        $display("FAIL bit_timing at cycle %0d: got malformed 8N1 character, want 4-cycle bits", t0);
                    end
                    start_q.push_back(t0);
                    rx_cnt++;
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL rx_byte unexpected: got %02h, want none", b);
                    end else begin
                        e = exp_q.pop_front();
                        if (b !== e) begin
                            n_err++;
                            $display("FAIL rx_byte: got %02h, want %02h", b, e);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    function automatic logic [7:0] hexc(input logic [3:0] d);
        return (d < 4'd10) ? 8'd48 + 8'(d) : 8'd65 + 8'(d) - 8'd10;
    endfunction

    task automatic push_frame(input logic [15:0] v);
        exp_q.push_back(8'h1B); exp_q.push_back(8'h5B); exp_q.push_back(8'h48);
        for (int c = 0; c < 2; c++) begin
            exp_q.push_back(8'h43);
            exp_q.push_back(hexc(4'(c)));
            exp_q.push_back(8'h3A);
            exp_q.push_back(8'h20);
            exp_q.push_back(hexc(v[c*8+4 +: 4]));
            exp_q.push_back(hexc(v[c*8 +: 4]));
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end
    endtask

    task automatic start_frame(input logic [15:0] v, input int hold, output int s_cyc);
        ch_values = v;
        push_frame(v);
        enable = 1'b1;
        s_cyc = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy) begin s_cyc = cyc; break; end
        end
        n_cmp++;
        if (s_cyc < 0) begin
            n_err++;
            $display("FAIL frame_start: got busy=0 after 100 cycles, want 1");
        end
        repeat (hold) @(negedge clk);
        enable = 1'b0;
    endtask

    task automatic wait_idle(output int fell, output int maxlvl);
        fell = -1; maxlvl = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (int'(fifo_level) > maxlvl) maxlvl = int'(fifo_level);
            if (!busy) begin fell = cyc; break; end
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_cmp++; if (tx !== 1'b1) begin n_err++; $display("FAIL reset_tx: got %b, want 1", tx); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b, want 0", busy); end
        n_cmp++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL reset_frame_done: got %b, want 0", frame_done); end
        n_cmp++; if (fifo_level !== 5'd0) begin n_err++; $display("FAIL reset_level: got %0d, want 0", fifo_level); end
    endtask

    task automatic test_holdoff;
        int r0, fb, fp, ft, f0, x0, fell, ml;
        f0 = fd_cnt; x0 = rx_cnt;
        ch_values = 16'hA53C;
        push_frame(16'hA53C);
        enable = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        r0 = cyc; fb = -1; fp = -1; ft = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (busy && fb < 0) begin fb = cyc - r0; enable = 1'b0; end
            if (fifo_level != 0 && fp < 0) fp = cyc - r0;
            if (tx === 1'b0 && ft < 0) begin ft = cyc - r0; break; end
        end
        n_cmp++; if (fb != 9) begin n_err++; $display("FAIL holdoff_snap_cycle: got %0d, want 9", fb); end
        n_cmp++; if (fp != 11) begin n_err++; $display("FAIL holdoff_first_push: got %0d, want 11", fp); end
        n_cmp++; if (ft != 12) begin n_err++; $display("FAIL holdoff_first_tx_low: got %0d, want 12", ft); end
        wait_idle(fell, ml);
        n_cmp++; if (fell < 0) begin n_err++; $display("FAIL holdoff_idle: got busy stuck, want idle"); end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL holdoff_missing: got %0d bytes outstanding, want 0", exp_q.size()); end
        n_cmp++; if (rx_cnt - x0 != 19) begin n_err++; $display("FAIL holdoff_rx_count: got %0d, want 19", rx_cnt - x0); end
        n_cmp++; if (fd_cnt - f0 != 1) begin n_err++; $display("FAIL holdoff_frame_done: got %0d, want 1", fd_cnt - f0); end
    endtask

    task automatic test_backpressure;
        int s, fell, ml, f0, bad;
        f0 = fd_cnt;
        start_q.delete();
        start_frame(16'hA53C, 0, s);
        wait_idle(fell, ml);
        n_cmp++; if (fell < 0) begin n_err++; $display("FAIL bp_idle: got busy stuck, want idle"); end
        n_cmp++; if (ml != 16) begin n_err++; $display("FAIL bp_max_level: got %0d, want 16", ml); end
        n_cmp++; if (start_q.size() != 19) begin n_err++; $display("FAIL bp_byte_count: got %0d, want 19", start_q.size()); end
        bad = 0;
        for (int i = 1; i < start_q.size(); i++) if (start_q[i] - start_q[i-1] != 40) bad++;
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL bp_gaps: got %0d non-40-cycle spacings, want 0", bad); end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL bp_missing: got %0d outstanding, want 0", exp_q.size()); end
        n_cmp++; if (fd_cnt - f0 != 1) begin n_err++; $display("FAIL bp_frame_done: got %0d, want 1", fd_cnt - f0); end
    endtask

    task automatic test_snapshot;
        int s, fell, ml, x0;
        x0 = rx_cnt;
        start_frame(16'hA53C, 0, s);
        repeat (8) @(negedge clk);
        ch_values = 16'h0000;
        wait_idle(fell, ml);
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL snap_first_missing: got %0d outstanding, want 0", exp_q.size()); end
        start_frame(16'h0000, 0, s);
        wait_idle(fell, ml);
        n_cmp++; if (fell < 0) begin n_err++; $display("FAIL snap_idle: got busy stuck, want idle"); end
        n_cmp++; if (rx_cnt - x0 != 38) begin n_err++; $display("FAIL snap_rx_count: got %0d, want 38", rx_cnt - x0); end
    endtask

    task automatic test_enable;
        int s, fell, ml, f0, viol;
        f0 = fd_cnt;
        start_q.delete();
        start_frame(16'h7F01, 12, s);
        wait_idle(fell, ml);
        n_cmp++;
        if (fell < 0 || start_q.size() == 0 || fell - start_q[$] != 40) begin
            n_err++;
            $display("FAIL enable_busy_fall: got cycle %0d, want last start + 40", fell);
        end
        viol = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || fifo_level !== 5'd0 || tx !== 1'b1) viol++;
        end
        n_cmp++; if (viol != 0) begin n_err++; $display("FAIL enable_no_new_frame: got %0d active cycles, want 0", viol); end
        n_cmp++; if (fd_cnt - f0 != 1) begin n_err++; $display("FAIL enable_frame_done: got %0d, want 1", fd_cnt - f0); end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL enable_missing: got %0d outstanding, want 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid;
        int e, r0, fb, fell, ml, f0, x0;
        ch_values = 16'hA53C;
        enable = 1'b1;
        e = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx === 1'b0) begin e = cyc; break; end
        end
        n_cmp++; if (e < 0) begin n_err++; $display("FAIL rmid_start: got no start bit, want one"); end
        repeat (17) @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++; if (tx !== 1'b1) begin n_err++; $display("FAIL rmid_tx: got %b, want 1", tx); end
        n_cmp++; if (fifo_level !== 5'd0) begin n_err++; $display("FAIL rmid_level: got %0d, want 0", fifo_level); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmid_busy: got %b, want 0", busy); end
        repeat (3) @(negedge clk);
        f0 = fd_cnt; x0 = rx_cnt;
        push_frame(16'hA53C);
        rst = 1'b0;
        r0 = cyc; fb = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (busy) begin fb = cyc - r0; break; end
        end
        enable = 1'b0;
        n_cmp++; if (fb != 9) begin n_err++; $display("FAIL rmid_holdoff: got %0d, want 9", fb); end
        wait_idle(fell, ml);
        n_cmp++; if (rx_cnt - x0 != 19) begin n_err++; $display("FAIL rmid_rx_count: got %0d, want 19", rx_cnt - x0); end
        n_cmp++; if (fd_cnt - f0 != 1) begin n_err++; $display("FAIL rmid_frame_done: got %0d, want 1", fd_cnt - f0); end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL rmid_missing: got %0d outstanding, want 0", exp_q.size()); end
    endtask

    initial begin
        rst = 1'b0;
        enable = 1'b0;
        ch_values = 16'h0000;
        #2 rst = 1'b1;
        test_reset;
        test_holdoff;
        test_backpressure;
        test_snapshot;
        test_enable;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
